// File: rtl/mem_responder.sv
// Single-port memory slave: captures one request, waits LAT cycles, then responds.
// ack is a registered strobe one edge after RESP, so it rises LAT+1 edges after capture.
module mem_responder #(
  parameter int WIDE  = 32,
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            we,
  input  logic [5:0]      addr,
  input  logic [WIDE-1:0] wd,
  output logic [WIDE-1:0] rd,
  output logic            ack,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_CNT  = 4'(LAT);
  localparam bit         ZERO_LAT = (LAT == 0);

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [5:0]      addr_q;
  logic [WIDE-1:0] wd_q;
  logic [WIDE-1:0] rd_q;
  logic            ack_q;

  logic [WIDE-1:0] mem [DEPTH];

  logic            capture;
  logic            enter_resp;
  logic            op_we;
  logic [5:0]      op_addr;
  logic [WIDE-1:0] op_wd;

  // With zero wait states the memory access happens on the capture edge itself,
  // so the operation comes straight from the inputs instead of the holding registers.
  always_comb begin
    capture    = (state_q == IDLE) && req;
    enter_resp = ZERO_LAT ? capture : ((state_q == WAIT) && (cnt_q == 4'd1));
    op_we      = ZERO_LAT ? we   : we_q;
    op_addr    = ZERO_LAT ? addr : addr_q;
    op_wd      = ZERO_LAT ? wd   : wd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 6'd0;
      wd_q    <= '0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= (state_q == RESP);
      if (enter_resp && !op_we) begin
        rd_q <= mem[op_addr];
      end
      case (state_q)
        IDLE: begin
          if (req) begin
            we_q   <= we;
            addr_q <= addr;
            wd_q   <= wd;
            if (ZERO_LAT) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_CNT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset; the rst gate keeps a held-in-reset request out of memory.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && op_we) begin
      mem[op_addr] <= op_wd;
    end
  end

  assign rd   = rd_q;
  assign ack  = ack_q;
  assign busy = (state_q != IDLE);

endmodule
